mpl2d_seq: RTL and testbench
============================

Name: mpl2d_seq

Overview:
Sequencer for the 2x2 max-pool unit (MPL2D) in the SFU. It walks the 16-element window order for each psum block, drives the pool unit's enable/order inputs, and issues psum SRAM reads. It also qualifies the pool unit's valid strobe into exactly one output-SRAM write per pooled pixel. It sits between the psum SRAM, the MPL2D datapath and the pooled-output SRAM, and is started by the top-level SFU controller.

Parameters:
BLK_W, 4, width of block counter; up to 2^BLK_W blocks of 16 psum entries per run
PSUM_AW, BLK_W+4, psum SRAM address width = {block, o_nij}

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; accepted only in IDLE
cfg_num_blk  in  BLK_W  number of blocks minus 1; sampled on accepted start
stall  in  1  psum SRAM not available this cycle
psum_rd_en  out  1  psum SRAM read strobe
psum_rd_addr  out  PSUM_AW  {blk, order[3], order[1], order[2], order[0]}
mpl_enable  out  1  MPL2D enable
mpl_order  out  4  MPL2D order (0..15)
mpl_valid  in  1  MPL2D MPL_valid
mpl_onij  in  2  MPL2D mpl_onij
out_wr_en  out  1  pooled-output SRAM write strobe
out_wr_addr  out  BLK_W+2  {blk_d1, mpl_onij}
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of run

Behaviour:
- Clocking and reset: clk; reset synchronous, active-high. Reset forces IDLE, order=0, blk=0, adv_d1=0, blk_d1=0. All outputs are 0 after reset, including mid-run; a partial run is abandoned and issues no done.
- FSM states: IDLE, RUN, DRAIN, DONE. Transitions:
  - IDLE -> RUN on start. Loads last_blk=cfg_num_blk, blk=0, order=0.
  - RUN -> DRAIN when order==15, blk==last_blk and !stall.
  - DRAIN -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
  - start outside IDLE is ignored.
- RUN: mpl_enable=1. If !stall: psum_rd_en=1, order advances by 1 (15 wraps to 0 and blk increments). If stall: psum_rd_en=0 and order/blk are held.
  - Stall is tolerated because the SRAM holds its last read data and max is idempotent on repeated data.
- Read data latency is 1 cycle; MPL2D internally delays order to match.
- adv_d1: registered (state==RUN && !stall). blk_d1: registered blk.
- out_wr_en = mpl_valid & adv_d1. This suppresses duplicate writes while a stall repeats order%4==3.
- DRAIN: mpl_enable=1, psum_rd_en=0; it completes the final window's write.
- DONE: mpl_enable=0, done=1 for one cycle.
- IDLE: mpl_enable=0, which clears the MPL2D accumulator.
- mpl_order output = order register while in RUN; 0 otherwise.
- busy=1 in RUN and DRAIN.
- Latency with no stall: start accepted at cycle 0; RUN cycles 1..16(N); DRAIN at 16N+1; done at 16N+2, where N=cfg_num_blk+1. Each stall cycle adds one cycle.
- Write count per run is exactly 4N, with out_wr_addr {b,0..3} in order for each block b.
- Block boundary: the write for window 3 of block b occurs in the cycle issuing order 0 of block b+1. That write uses blk_d1=b.

Test Plan:
- Single block: cfg_num_blk=0, start, no stall -> rd addrs in o_nij order 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15. Writes to out_wr_addr 0,1,2,3 at cycles 5,9,13,17; done at cycle 18.
- Three blocks, no stall -> 12 writes with addresses 0..11 in sequence. Write to 7 coincides with the read of block 2 order 0; done at cycle 50.
- Stall held 3 cycles at order 3, block 0 -> order/rd_addr frozen, psum_rd_en=0, exactly one write to address 0, done delayed by 3 cycles. Pooled values are unchanged versus the no-stall run.
- Stall at order 0 and at order 15 of the last block -> no extra writes. DRAIN is entered only after order 15 is issued with stall low.
- start pulsed during RUN -> ignored; write count and done timing are identical to the single-start run.
- reset asserted at RUN cycle 7 -> next cycle all outputs 0, state IDLE, no done. A following start runs a full sequence correctly.

Source files
------------

// File: rtl/mpl2d_seq.sv
// rtl/mpl2d_seq.sv - window-order sequencer for the 2x2 max-pool unit
// Issues psum reads, drives MPL2D enable/order, qualifies pooled-pixel writes.
module mpl2d_seq #(
  parameter int BLK_W   = 4,
  parameter int PSUM_AW = BLK_W + 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BLK_W-1:0]   cfg_num_blk,
  input  logic               stall,
  output logic               psum_rd_en,
  output logic [PSUM_AW-1:0] psum_rd_addr,
  output logic               mpl_enable,
  output logic [3:0]         mpl_order,
  input  logic               mpl_valid,
  input  logic [1:0]         mpl_onij,
  output logic               out_wr_en,
  output logic [BLK_W+1:0]   out_wr_addr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       order_q, order_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] last_blk_q, last_blk_d;
  logic             adv_d1_q, adv_d1_d;
  logic [BLK_W-1:0] blk_d1_q, blk_d1_d;

  logic adv;
  assign adv = (state_q == S_RUN) && !stall;

  always_comb begin
    state_d    = state_q;
    order_d    = order_q;
    blk_d      = blk_q;
    last_blk_d = last_blk_q;
    adv_d1_d   = adv;
    blk_d1_d   = blk_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          last_blk_d = cfg_num_blk;
          blk_d      = '0;
          order_d    = '0;
        end
      end
      S_RUN: begin
        // A stall freezes order/blk; the SRAM repeats its data and max is idempotent.
        if (!stall) begin
          order_d = order_q + 4'd1;
          if (order_q == 4'd15) begin
            if (blk_q == last_blk_q) begin
              state_d = S_DRAIN;
            end else begin
              blk_d = blk_q + 1'b1;
            end
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        order_d = '0;
        blk_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      order_q    <= '0;
      blk_q      <= '0;
      last_blk_q <= '0;
      adv_d1_q   <= 1'b0;
      blk_d1_q   <= '0;
    end else begin
      state_q    <= state_d;
      order_q    <= order_d;
      blk_q      <= blk_d;
      last_blk_q <= last_blk_d;
      adv_d1_q   <= adv_d1_d;
      blk_d1_q   <= blk_d1_d;
    end
  end

  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign mpl_enable   = busy;
  assign mpl_order    = (state_q == S_RUN) ? order_q : 4'd0;
  assign psum_rd_en   = adv;
  assign psum_rd_addr = (state_q == S_RUN)
                        ? PSUM_AW'({blk_q, order_q[3], order_q[1], order_q[2], order_q[0]})
                        : '0;
  // adv_d1 drops the repeated valids MPL2D emits while a stall holds order%4==3.
  assign out_wr_en    = mpl_valid & adv_d1_q;
  assign out_wr_addr  = out_wr_en ? {blk_d1_q, mpl_onij} : '0;

endmodule

// File: tb/tb_mpl2d_seq.sv
// tb/tb_mpl2d_seq.sv - directed self-checking bench for mpl2d_seq
// A small MPL2D stand-in raises valid one cycle after any enabled order%4==3.
module tb_mpl2d_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] cfg_num_blk = 4'd0;
  logic       psum_rd_en;
  logic [7:0] psum_rd_addr;
  logic       mpl_enable;
  logic [3:0] mpl_order;
  logic       mpl_valid;
  logic [1:0] mpl_onij;
  logic       out_wr_en;
  logic [5:0] out_wr_addr;
  logic       busy;
  logic       done;

  mpl2d_seq dut (
    .clk(clk), .reset(reset), .start(start), .cfg_num_blk(cfg_num_blk), .stall(stall),
    .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr), .mpl_enable(mpl_enable),
    .mpl_order(mpl_order), .mpl_valid(mpl_valid), .mpl_onij(mpl_onij),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset) begin
      mpl_valid <= 1'b0;
      mpl_onij  <= 2'd0;
    end else begin
      mpl_valid <= mpl_enable && (mpl_order[1:0] == 2'd3);
      mpl_onij  <= mpl_order[3:2];
    end
  end

  int cyc = 0;
  int t0 = 1 << 20;
  int n_assert = 0;
  int n_fail = 0;
  int done_cnt;
  int done_rel;

  logic       rden_l [128];
  logic [7:0] rda_l  [128];
  logic [3:0] ord_l  [128];
  logic       wren_l [128];
  logic [5:0] wra_l  [128];
  logic       done_l [128];
  logic       busy_l [128];
  logic       en_l   [128];
  logic [22:0] outs_l [128];

  int wr_c[$];
  int wr_a[$];
  int rd_a[$];
  int exp_wc[$];
  int rd_tab[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int r;
    r = cyc - t0;
    if (r >= 0 && r < 128) begin
      rden_l[r] = psum_rd_en;
      rda_l[r]  = psum_rd_addr;
      ord_l[r]  = mpl_order;
      wren_l[r] = out_wr_en;
      wra_l[r]  = out_wr_addr;
      done_l[r] = done;
      busy_l[r] = busy;
      en_l[r]   = mpl_enable;
      outs_l[r] = {psum_rd_en, psum_rd_addr, mpl_enable, mpl_order, out_wr_en, out_wr_addr, busy, done};
      if (done) begin
        done_cnt++;
        if (done_rel < 0) done_rel = r;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] nblk, input int s_lo0, input int s_hi0,
                     input int s_lo1, input int s_hi1, input int restart_at,
                     input int rst_at, input int max_rel);
    int rel;
    for (int i = 0; i < 128; i++) begin
      rden_l[i] = 1'b0; wren_l[i] = 1'b0; done_l[i] = 1'b0; busy_l[i] = 1'b0;
      en_l[i] = 1'b0; rda_l[i] = '0; wra_l[i] = '0; ord_l[i] = '0; outs_l[i] = '0;
    end
    done_cnt = 0;
    done_rel = -1;
    step();
    t0 = cyc;
    cfg_num_blk = nblk;
    start = 1'b1;
    stall = 1'b0;
    rel = 0;
    while (rel < max_rel) begin
      step();
      rel = cyc - t0;
      start = (rel == restart_at);
      if (rel == restart_at) cfg_num_blk = 4'd3;
      stall = (rel >= s_lo0 && rel < s_hi0) || (rel >= s_lo1 && rel < s_hi1);
      reset = (rel == rst_at);
      if (done_rel >= 0 && rel >= done_rel + 3) break;
    end
    start = 1'b0;
    stall = 1'b0;
    reset = 1'b0;
    step();
    t0 = 1 << 20;
    wr_c.delete();
    wr_a.delete();
    rd_a.delete();
    for (int i = 0; i < 128; i++) begin
      if (wren_l[i]) begin
        wr_c.push_back(i);
        wr_a.push_back(int'(wra_l[i]));
      end
      if (rden_l[i]) rd_a.push_back(int'(rda_l[i]));
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, 64'(wr_c.size()), 64'(exp_wc.size()));
    for (int i = 0; i < exp_wc.size(); i++) begin
      if (i < wr_c.size()) begin
        chk($sformatf("%s_wr%0d_cyc", tag, i), 64'(wr_c[i]), 64'(exp_wc[i]));
        chk($sformatf("%s_wr%0d_addr", tag, i), 64'(wr_a[i]), 64'(i));
      end
    end
  endtask

  task automatic check_single_block_reads(input string tag);
    chk({tag, "_rd_count"}, 64'(rd_a.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < rd_a.size()) chk($sformatf("%s_rd%0d", tag, i), 64'(rd_a[i]), 64'(rd_tab[i]));
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 64'({psum_rd_en, psum_rd_addr, mpl_enable, mpl_order,
                              out_wr_en, out_wr_addr, busy, done}), 64'd0);

    // single block, no stall
    run(4'd0, -1, -1, -1, -1, -1, -1, 60);
    check_single_block_reads("one");
    exp_wc = {5, 9, 13, 17};
    check_writes("one");
    chk("one_done_cyc", 64'(done_rel), 64'd18);
    chk("one_done_cnt", 64'(done_cnt), 64'd1);
    chk("one_busy_drain", 64'(busy_l[17]), 64'd1);
    chk("one_en_drain", 64'(en_l[17]), 64'd1);
    chk("one_rden_drain", 64'(rden_l[17]), 64'd0);
    chk("one_busy_done", 64'(busy_l[18]), 64'd0);
    chk("one_en_done", 64'(en_l[18]), 64'd0);
    chk("one_busy_start", 64'(busy_l[0]), 64'd0);
    chk("one_busy_run1", 64'(busy_l[1]), 64'd1);

    // three blocks, no stall
    run(4'd2, -1, -1, -1, -1, -1, -1, 120);
    exp_wc.delete();
    for (int k = 0; k < 12; k++) exp_wc.push_back(5 + 4 * k);
    check_writes("three");
    chk("three_rd_count", 64'(rd_a.size()), 64'd48);
    chk("three_boundary_wr", 64'(wra_l[33]), 64'd7);
    chk("three_boundary_rden", 64'(rden_l[33]), 64'd1);
    chk("three_boundary_rd", 64'(rda_l[33]), 64'd32);
    chk("three_last_rd", 64'(rda_l[48]), 64'd47);
    chk("three_done_cyc", 64'(done_rel), 64'd50);
    chk("three_done_cnt", 64'(done_cnt), 64'd1);

    // stall held three cycles at order 3 of block 0
    run(4'd0, 4, 7, -1, -1, -1, -1, 60);
    for (int r = 4; r < 7; r++) begin
      chk($sformatf("stl_ord_%0d", r), 64'(ord_l[r]), 64'd3);
      chk($sformatf("stl_rda_%0d", r), 64'(rda_l[r]), 64'd5);
      chk($sformatf("stl_rden_%0d", r), 64'(rden_l[r]), 64'd0);
    end
    chk("stl_rden_release", 64'(rden_l[7]), 64'd1);
    check_single_block_reads("stl");
    exp_wc = {8, 12, 16, 20};
    check_writes("stl");
    chk("stl_done_cyc", 64'(done_rel), 64'd21);

    // stall at order 0 and at order 15 of the last block
    run(4'd0, 1, 3, 18, 20, -1, -1, 60);
    exp_wc = {7, 11, 15, 21};
    check_writes("edge");
    chk("edge_busy_hold15", 64'(busy_l[19]), 64'd1);
    chk("edge_ord_hold15", 64'(ord_l[19]), 64'd15);
    chk("edge_rden_hold15", 64'(rden_l[19]), 64'd0);
    chk("edge_rden_issue15", 64'(rden_l[20]), 64'd1);
    chk("edge_drain_en", 64'(en_l[21]), 64'd1);
    chk("edge_drain_rden", 64'(rden_l[21]), 64'd0);
    chk("edge_done_cyc", 64'(done_rel), 64'd22);
    check_single_block_reads("edge");

    // start pulsed during RUN is ignored
    run(4'd0, -1, -1, -1, -1, 6, -1, 60);
    exp_wc = {5, 9, 13, 17};
    check_writes("restart");
    chk("restart_done_cyc", 64'(done_rel), 64'd18);
    chk("restart_done_cnt", 64'(done_cnt), 64'd1);

    // reset in RUN cycle 7 abandons the run
    run(4'd0, -1, -1, -1, -1, -1, 7, 30);
    chk("rst_outs_after", 64'(outs_l[8]), 64'd0);
    chk("rst_busy_late", 64'(busy_l[20]), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_wr_count", 64'(wr_c.size()), 64'd1);

    // a following start runs a full sequence
    run(4'd0, -1, -1, -1, -1, -1, -1, 60);
    check_single_block_reads("post");
    exp_wc = {5, 9, 13, 17};
    check_writes("post");
    chk("post_done_cyc", 64'(done_rel), 64'd18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
